// File: rtl/rvc_asap_mem_loader_if.sv
// Bundles the loader's host byte stream, memory write port and core run-control signals.
// slave: the loader itself; master: the host/core/memory side that drives it.
interface rvc_asap_mem_loader_if;
   logic        InValid;
   logic [7:0]  InData;
   logic        InReady;
   logic        MemWrEn;
   logic [31:0] MemWrAddr;
   logic [31:0] MemWrData;
   logic [3:0]  MemByteEn;
   logic        CoreRst;
   logic [31:0] Instruction101H;
   logic        EbreakSeen;
   logic        ErrRange;
   logic        ErrCmd;
   logic [31:0] RunCycles;

   modport slave (
      input  InValid, InData, Instruction101H,
      output InReady, MemWrEn, MemWrAddr, MemWrData, MemByteEn,
             CoreRst, EbreakSeen, ErrRange, ErrCmd, RunCycles
   );

   modport master (
      output InValid, InData, Instruction101H,
      input  InReady, MemWrEn, MemWrAddr, MemWrData, MemByteEn,
             CoreRst, EbreakSeen, ErrRange, ErrCmd, RunCycles
   );
endinterface

// File: rtl/rvc_asap_mem_loader.sv
// Host program loader: turns a command/address/length/payload byte stream into
// word writes with byte enables, and runs the core until it retires an ebreak.
module rvc_asap_mem_loader #(
   parameter logic [31:0] MEM_MSB       = 32'h0000_1FFF,
   parameter logic [7:0]  CMD_WRITE     = 8'hA1,
   parameter logic [7:0]  CMD_RUN       = 8'hA2,
   parameter logic [31:0] EBREAK_OPCODE = 32'h0010_0073
) (
   input  logic                        Clock,
   input  logic                        Rst,
   rvc_asap_mem_loader_if.slave        bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_LEN  = 3'd2,
      S_DATA = 3'd3,
      S_RUN  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] len_q, len_d;
   logic [31:0] asm_data_q, asm_data_d;
   logic [3:0]  asm_be_q, asm_be_d;
   logic        wr_en_q, wr_en_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic [3:0]  wr_be_q, wr_be_d;
   logic        core_rst_q, core_rst_d;
   logic        ebreak_q, ebreak_d;
   logic        err_range_q, err_range_d;
   logic        err_cmd_q, err_cmd_d;
   logic [31:0] run_cycles_q, run_cycles_d;

   logic        in_ready;
   logic        take;
   logic        in_range;
   logic [1:0]  lane;
   logic [31:0] merged_data;
   logic [3:0]  merged_be;

   // Payload byte merged into the assembly word; out-of-range bytes leave their lane disabled.
   always_comb begin
      lane        = addr_q[1:0];
      in_range    = (addr_q <= MEM_MSB);
      merged_data = asm_data_q;
      merged_be   = asm_be_q;
      if (in_range) begin
         merged_data[{lane, 3'b000} +: 8] = bus.InData;
         merged_be[lane]                  = 1'b1;
      end
   end

   assign in_ready = (state_q != S_RUN);
   assign take     = bus.InValid && in_ready;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      len_d        = len_q;
      asm_data_d   = asm_data_q;
      asm_be_d     = asm_be_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      wr_be_d      = wr_be_q;
      core_rst_d   = core_rst_q;
      ebreak_d     = ebreak_q;
      err_range_d  = err_range_q;
      err_cmd_d    = err_cmd_q;
      run_cycles_d = run_cycles_q;

      case (state_q)
         S_IDLE: begin
            if (take) begin
               if (bus.InData == CMD_WRITE) begin
                  state_d     = S_ADDR;
                  cnt_d       = 2'd0;
                  asm_data_d  = '0;
                  asm_be_d    = '0;
                  err_range_d = 1'b0;
                  err_cmd_d   = 1'b0;
               end else if (bus.InData == CMD_RUN) begin
                  state_d      = S_RUN;
                  core_rst_d   = 1'b0;
                  ebreak_d     = 1'b0;
                  run_cycles_d = '0;
               end else begin
                  err_cmd_d = 1'b1;
               end
            end
         end
         S_ADDR: begin
            if (take) begin
               // Little-endian: each new byte enters at the top and shifts down.
               addr_d = {bus.InData, addr_q[31:8]};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = S_LEN;
                  cnt_d   = 2'd0;
               end
            end
         end
         S_LEN: begin
            if (take) begin
               len_d = {bus.InData, len_q[15:8]};
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd1) begin
                  cnt_d   = 2'd0;
                  state_d = (len_d == 16'd0) ? S_IDLE : S_DATA;
               end
            end
         end
         S_DATA: begin
            if (take) begin
               if (!in_range) begin
                  err_range_d = 1'b1;
               end
               addr_d = addr_q + 32'd1;
               len_d  = len_q - 16'd1;
               if (lane == 2'd3 || len_q == 16'd1) begin
                  asm_data_d = '0;
                  asm_be_d   = '0;
                  if (merged_be != 4'd0) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = {addr_q[31:2], 2'b00};
                     wr_data_d = merged_data;
                     wr_be_d   = merged_be;
                  end
                  if (len_q == 16'd1) begin
                     state_d = S_IDLE;
                  end
               end else begin
                  asm_data_d = merged_data;
                  asm_be_d   = merged_be;
               end
            end
         end
         S_RUN: begin
            if (run_cycles_q != 32'hFFFF_FFFF) begin
               run_cycles_d = run_cycles_q + 32'd1;
            end
            if (bus.Instruction101H == EBREAK_OPCODE) begin
               ebreak_d   = 1'b1;
               core_rst_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         len_q        <= '0;
         asm_data_q   <= '0;
         asm_be_q     <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         wr_be_q      <= '0;
         core_rst_q   <= 1'b1;
         ebreak_q     <= 1'b0;
         err_range_q  <= 1'b0;
         err_cmd_q    <= 1'b0;
         run_cycles_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         asm_data_q   <= asm_data_d;
         asm_be_q     <= asm_be_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         wr_be_q      <= wr_be_d;
         core_rst_q   <= core_rst_d;
         ebreak_q     <= ebreak_d;
         err_range_q  <= err_range_d;
         err_cmd_q    <= err_cmd_d;
         run_cycles_q <= run_cycles_d;
      end
   end

   assign bus.InReady    = in_ready;
   assign bus.MemWrEn    = wr_en_q;
   assign bus.MemWrAddr  = wr_addr_q;
   assign bus.MemWrData  = wr_data_q;
   assign bus.MemByteEn  = wr_be_q;
   assign bus.CoreRst    = core_rst_q;
   assign bus.EbreakSeen = ebreak_q;
   assign bus.ErrRange   = err_range_q;
   assign bus.ErrCmd     = err_cmd_q;
   assign bus.RunCycles  = run_cycles_q;

endmodule

// File: doc/rvc_asap_mem_loader.md
Name: rvc_asap_mem_loader

Overview:
Program loader and run controller that sits upstream of the rvc_asap_5pl core and its memory wrapper, replacing backdoor memory forcing. Accepts a host byte stream (command, address, length, payload), assembles bytes into word writes with byte enables for the I_MEM/D_MEM write port, and holds the core in reset until a RUN command. While running, it watches the stage-101H instruction for ebreak, counts run cycles, then returns to accepting commands.

Parameters:
MEM_MSB, 'h1FFF, highest legal byte address (I_MEM 0x0000-0x0FFF plus D_MEM 0x1000-0x1FFF)
CMD_WRITE, 8'hA1, command byte that opens a write burst
CMD_RUN, 8'hA2, command byte that releases the core
EBREAK_OPCODE, 32'h00100073, instruction encoding that ends a run

Ports:
Clock  in  1  single clock, all state on rising edge
Rst  in  1  asynchronous, active-low reset
InValid  in  1  host byte valid
InData  in  8  host byte
InReady  out  1  loader accepts a byte this cycle; a byte transfers when InValid && InReady
MemWrEn  out  1  one-cycle write strobe to memory wrapper
MemWrAddr  out  32  word-aligned byte address, bits [1:0] always 0
MemWrData  out  32  write data, byte lanes per MemByteEn
MemByteEn  out  4  lane enables; bit k covers MemWrData[8k+7:8k]
CoreRst  out  1  active-high reset to core; 1 whenever core is not running
Instruction101H  in  32  core stage-101H instruction, sampled only in RUN
EbreakSeen  out  1  sticky: last run ended on ebreak
ErrRange  out  1  sticky: payload byte addressed above MEM_MSB was dropped
ErrCmd  out  1  sticky: unknown command byte received
RunCycles  out  32  cycles spent in RUN during last/current run, saturating

Behaviour:
- Reset (Rst=0, any time, including mid-burst or mid-run): state IDLE, InReady=1, MemWrEn=0, MemWrAddr=0, MemWrData=0, MemByteEn=0, CoreRst=1, EbreakSeen=0, ErrRange=0, ErrCmd=0, RunCycles=0; any partially assembled word is discarded, no write is emitted.
- States: IDLE, ADDR, LEN, DATA, RUN.
- IDLE: byte==CMD_WRITE -> ADDR; byte==CMD_RUN -> RUN; any other byte -> set ErrCmd, stay IDLE.
- ADDR: 4 bytes, little-endian, form start address A -> LEN. LEN: 2 bytes, little-endian, form length L; L==0 -> IDLE with no write, else DATA.
- DATA: payload byte i goes to address A+i (32-bit wrap). Lane = (A+i)[1:0]; byte placed in assembly register, lane enable set.
- Write emission: when accepted byte has lane 3 or is byte L-1, next cycle MemWrEn=1 for exactly one cycle with MemWrAddr={(A+i)[31:2],2'b00}, assembled data/enables; assembly register cleared in the same edge. Back-to-back writes legal every 4th accepted byte; no back-pressure from memory.
- Unaligned start: first word carries only lanes A[1:0]..3; final word carries lanes 0..(A+L-1)[1:0].
- Range: byte with address > MEM_MSB is not placed (its lane stays disabled), ErrRange set; still counts toward L. A word with no enabled lanes emits no write.
- After byte L-1 -> IDLE. InReady=1 in IDLE, ADDR, LEN, DATA.
- RUN: entry edge drives CoreRst=0, clears EbreakSeen and RunCycles; InReady=0. Each RUN cycle RunCycles+1, saturating at 0xFFFFFFFF. When Instruction101H==EBREAK_OPCODE: EbreakSeen=1, CoreRst=1 next cycle, -> IDLE. Host reloads or reruns from IDLE.
- Error flags clear only on reset or (ErrRange/ErrCmd) on CMD_WRITE acceptance.

Test Plan:
- Aligned burst: A1, addr 00 00 00 00, len 08 00, bytes 13 00 10 00 73 00 10 00 -> two writes: addr 0x0 data 0x00100013 BE 0xF, addr 0x4 data 0x00100073 BE 0xF, one cycle after 4th and 8th payload bytes.
- Unaligned burst: addr 0x1002, len 3, bytes AA BB CC -> addr 0x1000 data 0xBBAA0000 BE 0xC; addr 0x1004 data 0x000000CC BE 0x1.
- Range/len/cmd: addr 0x1FFE, len 4 -> one write addr 0x1FFC BE 0xC, no write at 0x2000, ErrRange=1; len 0 -> no write; byte 0x55 in IDLE -> ErrCmd=1, state IDLE.
- Run: A2 -> CoreRst falls next edge, InReady=0; drive Instruction101H=0x00100073 after 20 cycles -> EbreakSeen=1, RunCycles=20, CoreRst=1, InReady=1.
- Reset mid-burst after 3 of 4 payload bytes -> no MemWrEn ever, all outputs at reset values, next A1 burst works normally.
- InValid stalls: deassert InValid for 5 cycles between payload bytes -> identical writes to unstalled case, no spurious MemWrEn.
